// File: rtl/wb_unified_test_mem_pkg.sv
// Shared types and constants for the unified Wishbone test memory.
// Port FSM states, reset/NOP values and the byte-lane merge helper.
package wb_unified_test_mem_pkg;

  typedef enum logic [1:0] {
    MEMP_IDLE = 2'd0,
    MEMP_WAIT = 2'd1,
    MEMP_RESP = 2'd2
  } memp_state_e;

  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] TOHOST_PASS = 32'h0000_0001;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_mem_port_ctrl.sv
// Per-port Wishbone handshake: IDLE -> WAIT -> RESP -> IDLE with programmable wait states.
// 'fire' marks the edge on which the top samples address/data; 'ack' is the registered pulse.
module wb_mem_port_ctrl
  import wb_unified_test_mem_pkg::*;
#(
  parameter int WAIT_W = 4,
  parameter int WAIT   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic fire,
  output logic ack
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

  memp_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEMP_IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= fire;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      MEMP_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT == 0) ? MEMP_RESP : MEMP_WAIT;
        end
      end
      MEMP_WAIT: begin
        if (!req) begin
          state_d = MEMP_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WAIT_LAST) state_d = MEMP_RESP;
        end
      end
      MEMP_RESP: begin
        fire    = 1'b1;
        state_d = MEMP_IDLE;
      end
      default: state_d = MEMP_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_unified_test_mem.sv
// Unified instruction/data word memory with two Wishbone slave ports and a tohost monitor.
// Data-port writes are visible to instruction fetches; iwb reads see the old word on collision.
module wb_unified_test_mem
  import wb_unified_test_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int IWAIT        = 0,
  parameter int DWAIT        = 0,
  parameter int TOHOST_WADDR = 1024,
  parameter int RANGE_CHECK  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        test_done_o,
  output logic        test_pass_o,
  output logic [30:0] fail_code_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TOHOST_IDX = ADDR_WIDTH'(TOHOST_WADDR);

  logic [31:0] mem [DEPTH];

  logic                  ifire, dfire, dresp, derr_q;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic                  d_range_err, d_write, tohost_hit;
  logic                  unused_bits;

  wb_mem_port_ctrl #(.WAIT_W(4), .WAIT(IWAIT)) u_iwb_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (iwb_cyc_i & iwb_stb_i),
    .fire  (ifire),
    .ack   (iwb_ack_o)
  );

  wb_mem_port_ctrl #(.WAIT_W(4), .WAIT(DWAIT)) u_dwb_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (dwb_cyc_i & dwb_stb_i),
    .fire  (dfire),
    .ack   (dresp)
  );

  // The instruction port wraps on high address bits; byte offsets are ignored on both ports.
  assign i_idx       = iwb_adr_i[ADDR_WIDTH+1:2];
  assign d_idx       = dwb_adr_i[ADDR_WIDTH+1:2];
  assign unused_bits = ^{iwb_adr_i[31:ADDR_WIDTH+2], iwb_adr_i[1:0], dwb_adr_i[1:0]};

  assign d_range_err = (RANGE_CHECK != 0) && (dwb_adr_i[31:ADDR_WIDTH+2] != '0);
  assign d_write     = dfire && dwb_we_i && !d_range_err;
  assign tohost_hit  = d_write && (d_idx == TOHOST_IDX) && (dwb_dat_i != '0) &&
                       (dwb_sel_i == 4'hF);

  assign dwb_ack_o = dresp & ~derr_q;
  assign dwb_err_o = dresp & derr_q;

  // NOTE: the array has no reset; contents survive rst_n and an aborted access never writes.
  always_ff @(posedge clk) begin
    if (d_write) mem[d_idx] <= lane_merge(mem[d_idx], dwb_dat_i, dwb_sel_i);
  end

  // Reads take the pre-edge array value, giving read-before-write on a same-word collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iwb_dat_o   <= NOP_INSN;
      dwb_dat_o   <= '0;
      derr_q      <= 1'b0;
      test_done_o <= 1'b0;
      test_pass_o <= 1'b0;
      fail_code_o <= '0;
    end else begin
      derr_q <= dfire & d_range_err;
      if (ifire) iwb_dat_o <= mem[i_idx];
      if (dfire && !dwb_we_i && !d_range_err) dwb_dat_o <= mem[d_idx];
      if (tohost_hit && !test_done_o) begin
        test_done_o <= 1'b1;
        test_pass_o <= (dwb_dat_i == TOHOST_PASS);
        fail_code_o <= dwb_dat_i[31:1];
      end
    end
  end

endmodule

// File: tb/tb_wb_unified_test_mem.sv
// Directed bench for wb_unified_test_mem with a cycle-level reference model and per-cycle compare.
// The model schedules each response by due cycle and keeps memory as a sparse word map.
module tb_wb_unified_test_mem;

  localparam int AW     = 13;
  localparam int IW     = 0;
  localparam int DW     = 3;
  localparam int WORDS  = 1 << AW;
  localparam int TOHOST = 1024;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iwb_adr_i = '0;
  logic        iwb_cyc_i = 1'b0, iwb_stb_i = 1'b0;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic [31:0] dwb_adr_i = '0, dwb_dat_i = '0;
  logic        dwb_we_i = 1'b0;
  logic [3:0]  dwb_sel_i = '0;
  logic        dwb_cyc_i = 1'b0, dwb_stb_i = 1'b0;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o, dwb_err_o;
  logic        test_done_o, test_pass_o;
  logic [30:0] fail_code_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  wb_unified_test_mem #(
    .ADDR_WIDTH(AW), .IWAIT(IW), .DWAIT(DW), .TOHOST_WADDR(TOHOST), .RANGE_CHECK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
    .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .test_done_o(test_done_o), .test_pass_o(test_pass_o), .fail_code_o(fail_code_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [int];
  bit          ipend = 0, dpend = 0;
  int          idue = 0, ddue = 0, ecnt = 0;
  logic        m_iack = 0, m_dack = 0, m_derr = 0, m_done = 0, m_pass = 0;
  logic [31:0] m_idat = 32'h13, m_ddat = 0;
  logic [30:0] m_code = 0;

  function automatic int widx(input logic [31:0] adr);
    return int'((adr >> 2) % WORDS);
  endfunction

  function automatic logic [31:0] rd(input int w);
    return mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ipend = 0; dpend = 0;
      m_iack = 0; m_dack = 0; m_derr = 0;
      m_idat = 32'h13; m_ddat = 0;
      m_done = 0; m_pass = 0; m_code = 0;
    end else begin
      bit i_fire, d_fire;
      ecnt++;
      m_iack = 0; m_dack = 0; m_derr = 0;
      i_fire = ipend && (ecnt == idue);
      d_fire = dpend && (ecnt == ddue);
      if (i_fire) begin
        m_iack = 1;
        m_idat = rd(widx(iwb_adr_i));
      end
      if (d_fire) begin
        if (dwb_adr_i >= 32'(WORDS * 4)) begin
          m_derr = 1;
        end else begin
          int w;
          logic [31:0] mask;
          w = widx(dwb_adr_i);
          m_dack = 1;
          if (dwb_we_i) begin
            mask = {{8{dwb_sel_i[3]}}, {8{dwb_sel_i[2]}}, {8{dwb_sel_i[1]}}, {8{dwb_sel_i[0]}}};
            mem_m[w] = (rd(w) & ~mask) | (dwb_dat_i & mask);
            if (w == TOHOST && dwb_dat_i != 0 && dwb_sel_i == 4'hF && !m_done) begin
              m_done = 1;
              m_pass = (dwb_dat_i == 32'd1);
              m_code = 31'(dwb_dat_i / 2);
            end
          end else begin
            m_ddat = rd(w);
          end
        end
      end
      if (i_fire) ipend = 0;
      else if (ipend && !(iwb_cyc_i && iwb_stb_i)) ipend = 0;
      else if (!ipend && iwb_cyc_i && iwb_stb_i) begin ipend = 1; idue = ecnt + 1 + IW; end
      if (d_fire) dpend = 0;
      else if (dpend && !(dwb_cyc_i && dwb_stb_i)) dpend = 0;
      else if (!dpend && dwb_cyc_i && dwb_stb_i) begin dpend = 1; ddue = ecnt + 1 + DW; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("iwb_ack", 32'(iwb_ack_o), 32'(m_iack));
      check("dwb_ack", 32'(dwb_ack_o), 32'(m_dack));
      check("dwb_err", 32'(dwb_err_o), 32'(m_derr));
      if (m_iack) check("iwb_dat", iwb_dat_o, m_idat);
      if (m_dack) check("dwb_dat", dwb_dat_o, m_ddat);
      check("test_done", 32'(test_done_o), 32'(m_done));
      check("test_pass", 32'(test_pass_o), 32'(m_pass));
      check("fail_code", 32'(fail_code_o), 32'(m_code));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic dwb_access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                            input logic [3:0] sel, output logic [31:0] rdat, output int lat,
                            output logic err);
    int k;
    @(posedge clk); #1;
    dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = sel;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(posedge clk);
    for (k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (dwb_ack_o || dwb_err_o) break;
    end
    lat  = k;
    rdat = dwb_dat_o;
    err  = dwb_err_o;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    if (k >= BUDGET) begin
      n_checks++; n_fail++;
      $display("FAIL dwb_timeout: got no response after %0d cycles, required one", k);
    end
  endtask

  task automatic iwb_fetch(input logic [31:0] adr, output logic [31:0] rdat, output int lat);
    int k;
    @(posedge clk); #1;
    iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    @(posedge clk);
    for (k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (iwb_ack_o) break;
    end
    lat  = k;
    rdat = iwb_dat_o;
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    if (k >= BUDGET) begin
      n_checks++; n_fail++;
      $display("FAIL iwb_timeout: got no ack after %0d cycles, required one", k);
    end
  endtask

  task automatic dwb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r; int l; logic e;
    dwb_access(adr, dat, 1'b1, sel, r, l, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iwb_dat"}, iwb_dat_o, 32'h0000_0013);
    check({tag, "_dwb_dat"}, dwb_dat_o, 32'h0);
    check({tag, "_acks"}, {29'd0, iwb_ack_o, dwb_ack_o, dwb_err_o}, 32'h0);
    check({tag, "_flags"}, {test_done_o, test_pass_o, fail_code_o[29:0]}, 32'h0);
    check({tag, "_code_msb"}, 32'(fail_code_o[30]), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int          lat, acks;
    logic        e;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    chk_en = 1'b1;

    // Image: word0 instruction, 0x200 data, word 0x40 for the collision case.
    dwb_write(32'h0000_0000, 32'h0050_0093, 4'hF);
    dwb_write(32'h0000_0200, 32'h1122_3344, 4'hF);
    dwb_write(32'h0000_0100, 32'hCAFE_F00D, 4'hF);

    // Fetch with zero wait states, byte offset ignored, high bits wrap.
    iwb_fetch(32'h0000_0000, d, lat);
    check("t1_fetch_data", d, 32'h0050_0093);
    check("t1_fetch_lat", 32'(lat), 32'd1);
    iwb_fetch(32'h0000_0003, d, lat);
    check("t1_offset_data", d, 32'h0050_0093);
    iwb_fetch(32'h0000_8000, d, lat);
    check("t1_wrap_data", d, 32'h0050_0093);

    // Back-to-back fetches held for 8 cycles: ack every 2nd cycle.
    @(posedge clk); #1;
    iwb_adr_i = 32'h0; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    @(posedge clk);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (iwb_ack_o) acks++;
    end
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    check("t1_b2b_acks", 32'(acks), 32'd4);

    // Partial-lane write with DWAIT=3, then sel=0 write.
    dwb_access(32'h0000_0200, 32'hAABB_CCDD, 1'b1, 4'b0101, d, lat, e);
    check("t2_write_lat", 32'(lat), 32'd4);
    dwb_access(32'h0000_0200, 32'h0, 1'b0, 4'hF, d, lat, e);
    check("t2_readback", d, 32'h11BB_33DD);
    dwb_write(32'h0000_0200, 32'hFFFF_FFFF, 4'h0);
    dwb_access(32'h0000_0200, 32'h0, 1'b0, 4'hF, d, lat, e);
    check("t2_sel0_unchanged", d, 32'h11BB_33DD);

    // Out-of-range data accesses.
    dwb_access(32'h0001_0000, 32'h0, 1'b0, 4'hF, d, lat, e);
    check("t3_read_err", 32'(e), 32'd1);
    dwb_access(32'h0001_0200, 32'hDEAD_BEEF, 1'b1, 4'hF, d, lat, e);
    check("t3_write_err", 32'(e), 32'd1);
    dwb_access(32'h0000_0200, 32'h0, 1'b0, 4'hF, d, lat, e);
    check("t3_mem_unchanged", d, 32'h11BB_33DD);

    // tohost pass, then a later write leaves flags alone.
    dwb_write(32'h0000_1000, 32'h1, 4'hF);
    check("t4_done_pass", {30'd0, test_done_o, test_pass_o}, 32'h3);
    dwb_write(32'h0000_1000, 32'h7, 4'hF);
    check("t4_sticky", {test_done_o, test_pass_o, fail_code_o[29:0]}, 32'hC000_0000);

    // Same-edge iwb read / dwb write on word 0x40.
    fork
      dwb_write(32'h0000_0100, 32'h1234_5678, 4'hF);
      begin
        logic [31:0] id; int il;
        repeat (3) @(posedge clk);
        iwb_fetch(32'h0000_0100, id, il);
        check("t6_collision_old", id, 32'hCAFE_F00D);
      end
    join
    iwb_fetch(32'h0000_0100, d, lat);
    check("t6_new_visible", d, 32'h1234_5678);

    // Reset during data wait states abandons the write.
    @(posedge clk); #1;
    dwb_adr_i = 32'h0000_0100; dwb_dat_i = 32'h0BAD_BEEF; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    #1 check_reset_outputs("t6_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    iwb_fetch(32'h0000_0100, d, lat);
    check("t6_write_aborted", d, 32'h1234_5678);

    // tohost: zero and partial-lane writes do not arm the monitor; then a failing code.
    dwb_write(32'h0000_1000, 32'h0, 4'hF);
    check("t5_zero_no_done", 32'(test_done_o), 32'd0);
    dwb_write(32'h0000_1000, 32'hB, 4'h7);
    check("t5_partial_no_done", 32'(test_done_o), 32'd0);
    dwb_write(32'h0000_1000, 32'hB, 4'hF);
    check("t5_done_fail", {30'd0, test_done_o, test_pass_o}, 32'h2);
    check("t5_fail_code", 32'(fail_code_o), 32'd5);
    dwb_access(32'h0000_1000, 32'h0, 1'b0, 4'hF, d, lat, e);
    check("t5_tohost_mem", d, 32'h0000_000B);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
